// File: rtl/argmax_select.sv
// Argmax over a serial vector of M signed words.
// Emits index and value of the largest word per vector.
module argmax_select #(
  parameter int M    = 3,
  parameter int T    = 8,
  parameter int LOGM = (M > 1) ? $clog2(M) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [T-1:0]    data_in,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [LOGM-1:0] idx_out,
  output logic [T-1:0]    max_out
);

  typedef enum logic {
    ACC,
    OUT
  } state_t;

  localparam logic [LOGM-1:0] LAST = LOGM'(M - 1);

  state_t                state;
  logic [LOGM-1:0]       count;
  logic signed [T-1:0]   best_val;
  logic [LOGM-1:0]       best_idx;
  logic signed [T-1:0]   win_val;
  logic [LOGM-1:0]       win_idx;

  // Accept words only while collecting and never in reset.
  always_comb begin
    s_ready = !reset && (state == ACC);
  end

  // Winner including the word offered this cycle; word 0 seeds.
  always_comb begin
    win_val = best_val;
    win_idx = best_idx;
    if (count == '0) begin
      win_val = $signed(data_in);
      win_idx = '0;
    end else if ($signed(data_in) > best_val) begin
      win_val = $signed(data_in);
      win_idx = count;
    end
  end

  // Collect/hold state machine with registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACC;
      count    <= '0;
      best_val <= '0;
      best_idx <= '0;
      m_valid  <= 1'b0;
      idx_out  <= '0;
      max_out  <= '0;
    end else begin
      unique case (state)
        ACC: begin
          if (s_valid) begin
            best_val <= win_val;
            best_idx <= win_idx;
            if (count == LAST) begin
              count   <= '0;
              state   <= OUT;
              m_valid <= 1'b1;
              idx_out <= win_idx;
              max_out <= win_val;
            end else begin
              count <= count + LOGM'(1);
            end
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_select.sv
// Scoreboard bench for argmax_select (M=3, T=8).
// Expected results are queued at stimulus time.
module tb_argmax_select;

  localparam int M = 3;
  localparam int T = 8;
  localparam int LOGM = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            s_valid;
  logic            s_ready;
  logic [T-1:0]    data_in;
  logic            m_valid;
  logic            m_ready;
  logic [LOGM-1:0] idx_out;
  logic [T-1:0]    max_out;

  typedef struct {
    int idx;
    int val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  argmax_select #(.M(M), .T(T)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .data_in (data_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .idx_out (idx_out),
    .max_out (max_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_argmax(input int a, input int b, input int c);
    int   v[3];
    exp_t r;
    v[0] = a;
    v[1] = b;
    v[2] = c;
    r.idx = 0;
    r.val = v[0];
    for (int i = 1; i < 3; i++) begin
      if (v[i] > r.val) begin
        r.idx = i;
        r.val = v[i];
      end
    end
    return r;
  endfunction

  // Pop and compare every output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_extra", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_idx", int'(idx_out), e.idx);
        check("sb_max", int'($signed(max_out)), e.val);
      end
    end
  end

  task automatic send_word(input int d);
    int n = 0;
    data_in = T'(d);
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("s_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_vec(input int a, input int b, input int c);
    sb.push_back(ref_argmax(a, b, c));
    send_word(a);
    send_word(b);
    send_word(c);
  endtask

  task automatic drive_cycle(input logic v, input int d);
    s_valid = v;
    data_in = T'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    exp_t e;
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", int'(s_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_idx", int'(idx_out), 0);
    check("rst_max", int'(max_out), 0);
    check("rst_s_ready_rel", int'(s_ready), 1);
    @(posedge clk);
    #1;

    // Back-to-back vector with ready downstream.
    m_ready = 1'b1;
    send_vec(7, -3, 20);
    @(negedge clk);
    check("lat_valid", int'(m_valid), 1);
    check("lat_idx", int'(idx_out), 2);
    check("lat_max", int'($signed(max_out)), 20);
    @(negedge clk);
    check("lat_drop", int'(m_valid), 0);
    @(posedge clk);
    #1;

    // Ties and negatives.
    send_vec(5, 5, 1);
    send_vec(-8, -4, -100);
    send_vec(-128, -128, -128);
    drain();
    @(posedge clk);
    #1;

    // Backpressure with an offered word that must be ignored.
    m_ready = 1'b0;
    send_vec(1, 9, 3);
    s_valid = 1'b1;
    data_in = T'(50);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", int'(m_valid), 1);
      check("bp_idx", int'(idx_out), 1);
      check("bp_max", int'($signed(max_out)), 9);
      check("bp_s_ready", int'(s_ready), 0);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_s_ready_hs", int'(s_ready), 0);
    @(negedge clk);
    check("bp_valid_after", int'(m_valid), 0);
    check("bp_s_ready_after", int'(s_ready), 1);
    @(posedge clk);
    #1;

    // Bubbles between words.
    e.idx = 1;
    e.val = 6;
    sb.push_back(e);
    drive_cycle(1'b1, 4);
    drive_cycle(1'b0, int'($urandom_range(0, 255)));
    drive_cycle(1'b0, int'($urandom_range(0, 255)));
    drive_cycle(1'b1, 6);
    drive_cycle(1'b0, int'($urandom_range(0, 255)));
    drive_cycle(1'b1, 2);
    s_valid = 1'b0;
    drain();
    @(posedge clk);
    #1;

    // Reset in the middle of a vector.
    send_word(100);
    send_word(50);
    reset = 1'b1;
    @(negedge clk);
    check("mr_s_ready", int'(s_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mr_m_valid", int'(m_valid), 0);
    check("mr_max", int'(max_out), 0);
    @(posedge clk);
    #1;
    send_vec(1, 2, 3);
    drain();
    @(posedge clk);
    #1;

    // Streaming with random downstream stalls and upstream gaps.
    fork
      begin
        for (int v = 0; v < 3; v++) begin
          int w[3];
          for (int k = 0; k < 3; k++) begin
            logic signed [T-1:0] b;
            b = T'($urandom);
            w[k] = int'(b);
          end
          sb.push_back(ref_argmax(w[0], w[1], w[2]));
          for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            send_word(w[k]);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
      end
    join
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
